ads5296x4_tx_emulator: RTL
==========================

Name: ads5296x4_tx_emulator

Overview:
- Transmit-side model of the ADS5296 2-wire, 10x serial interface for 4*G_NUM_UNITS channels.
- Emits per-lane 4-bit parallel words plus the matching frame-clock word every lclk_d4 cycle, intended to drive OSERDESE3 (DATA_WIDTH 4) instances.
- Used for loopback and bring-up of the ADS5296 receive path: user sample streaming, ramp, fixed and deskew patterns.

Parameters:
- G_NUM_UNITS, 4, number of ADS5296 devices emulated. NCH = 4*G_NUM_UNITS channels; NLANE = 2*NCH lanes.

Ports:
- lclk_d4  input  1  word clock, one 4-bit word per lane per cycle.
- rst  input  1  reset: synchronous, active-high, on lclk_d4.
- enable  input  1  when 0, lanes carry zero samples; fclk still runs.
- mode  input  2  0 user data, 1 ramp, 2 fixed, 3 deskew.
- fixed_pattern  input  10  sample value used in mode 2.
- din  input  10*NCH  user samples; channel c is din[10c+9:10c].
- din_valid  input  1  din holds a valid sample set.
- din_ready  output  1  din is consumed this cycle when din_valid && din_ready.
- dout4b  output  4*NLANE  lane l word is dout4b[4l+3:4l]; bit 0 is serialized first.
- fclk4b  output  4  frame-clock word, same bit order as dout4b.
- frame_start  output  1  high in the cycle whose outputs begin a 4-frame group.
- underflow_cnt  output  16  saturating count of mode-0 frames with no valid sample.

Behaviour:
- Frame format:
  - One frame is 5 bit-times per lane.
  - Channel c, lane 2c carries sample[9:5] MSB first.
  - Channel c, lane 2c+1 carries sample[4:0] MSB first.
  - Each frame's fclk bits are 1,1,1,0,0.
- Gearbox:
  - Phase counter cycles 0,1,2,3,4,0,… and advances every cycle after reset.
  - Each lane has an accumulator of up to 8 bits, plus one shared accumulator for fclk.
  - In phases 0-3: load one new 5-bit frame, then emit the oldest 4 bits.
  - In phase 4: load nothing and emit the remaining 4 bits.
  - Fill levels after emit, for phases 0..4: 1, 2, 3, 4, 0.
  - 4 frames are carried in 5 cycles.
- Output fclk4b sequence for phases 0..4 (hex): 7, E, C, 9, 3, repeating.
- frame_start is high with the phase-0 output word.
- Outputs are registered. A frame loaded in cycle t starts appearing on dout4b in cycle t+1.
- Sample source per frame, decided at load time:
  - enable=0: sample 0.
  - mode 0: din if din_valid, else 0.
  - mode 1: ramp value; all channels carry the same value.
  - mode 2: fixed_pattern.
  - mode 3: 10'h2AA.
- The enable/mode pair is sampled only in phase 4 and applies from the next phase 0. Changes therefore land on 4-frame group boundaries.
- Mode-0 handshake:
  - din_ready = 1 in phases 0-3 when the latched mode is 0 and the latched enable is 1. Otherwise din_ready = 0.
  - din is consumed only when din_valid && din_ready.
  - A phase-0..3 load with din_valid=0 sends 0 and increments underflow_cnt.
  - underflow_cnt saturates at 16'hFFFF and is cleared only by rst.
- Ramp:
  - 10-bit counter, incremented after each loaded frame while in mode 1.
  - Wraps from 1023 to 0.
  - Holds its value in other modes and resets to 0.
- Reset values:
  - phase 0; all accumulators empty; latched enable/mode = 0; ramp = 0.
  - dout4b = 0, fclk4b = 0, frame_start = 0, din_ready = 0, underflow_cnt = 0.
- First cycle after rst deasserts: phase 0 load. The next cycle outputs fclk4b=7 with frame_start=1.
- rst asserted mid-group:
  - Aborts immediately; partial frames are discarded.
  - Outputs return to reset values in the next cycle.

Test Plan:
- Reset then run 20 cycles, enable=0 -> fclk4b repeats 7,E,C,9,3 starting the cycle after the first load; frame_start every 5th cycle; dout4b all 0.
- enable=1, mode 2, fixed_pattern=10'h3E0 -> lane 2c serial stream is all 1s and lane 2c+1 is all 0s; per-channel words F,F,F,F,F and 0.
- mode 1 for 1100 frames -> deserialized ramp reads 0,1,…,1023,0,1,…; all channels equal.
- mode 0, din_valid toggling every other cycle with incrementing samples -> din_ready low in phase 4; accepted samples appear in order; underflow_cnt equals the number of phase-0..3 cycles with din_valid=0.
- mode changed from 3 to 2 in phase 1 -> frames 1-3 of the current group still show 10'h2AA; fixed_pattern starts at the next phase 0.
- rst asserted in phase 2 for 1 cycle -> next cycle all outputs are 0 and underflow_cnt is 0; the cycle after that begins with fclk4b=7 and frame_start=1.

Source files
------------

// File: rtl/ads5296x4_tx_emulator.sv
// ADS5296 2-wire 10x transmit emulator: packs 5-bit frames into 4-bit OSERDES words,
// four frames per five lclk_d4 cycles, with user/ramp/fixed/deskew sample sources.
module ads5296x4_tx_emulator #(
  parameter int G_NUM_UNITS = 4
) (
  input  logic                      lclk_d4,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [9:0]                fixed_pattern,
  input  logic [40*G_NUM_UNITS-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [32*G_NUM_UNITS-1:0] dout4b,
  output logic [3:0]                fclk4b,
  output logic                      frame_start,
  output logic [15:0]               underflow_cnt
);
  localparam int NCH = 4*G_NUM_UNITS;
  localparam int NLANE = 2*NCH;
  localparam logic [9:0] C_DESKEW = 10'h2AA;

  // phase | meaning
  // 0-3   | load one frame (fill before load = phase), emit oldest 4 bits
  // 4     | no load, flush remaining 4 bits, latch enable/mode
  logic [2:0] r_phase;
  logic [2:0] w_phase_nxt;
  logic       w_load;
  logic       w_din_ready;
  logic       w_frame_start_nxt;

  logic                   r_en;
  logic [1:0]             r_mode;
  logic [9:0]             r_ramp;
  logic [15:0]            r_uf;
  logic [NLANE-1:0][3:0]  r_acc;
  logic [3:0]             r_fclk_acc;
  logic [NLANE-1:0][3:0]  r_dout;
  logic [3:0]             r_fclk;
  logic                   r_fs;

  logic [NCH-1:0][9:0]    w_sample;
  logic [NLANE-1:0][4:0]  w_frame;
  logic [NLANE-1:0][7:0]  w_comb;
  logic [7:0]             w_fclk_comb;

  always_ff @(posedge lclk_d4) begin
    if (rst) r_phase <= 3'd0;
    else     r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
  end

  always_comb begin
    w_load            = (r_phase != 3'd4);
    w_din_ready       = w_load && r_en && (r_mode == 2'd0);
    w_frame_start_nxt = (r_phase == 3'd0);
  end

  always_comb begin
    w_sample = '0;
    if (r_en) begin
      for (int c = 0; c < NCH; c++) begin
        case (r_mode)
          2'd0:    w_sample[c] = din_valid ? din[10*c +: 10] : 10'd0;
          2'd1:    w_sample[c] = r_ramp;
          2'd2:    w_sample[c] = fixed_pattern;
          default: w_sample[c] = C_DESKEW;
        endcase
      end
    end
  end

  // Frames are stored bit-reversed so that bit 0 is the first bit on the wire.
  always_comb begin
    w_frame = '0;
    for (int c = 0; c < NCH; c++) begin
      w_frame[2*c]   = {w_sample[c][5], w_sample[c][6], w_sample[c][7],
                        w_sample[c][8], w_sample[c][9]};
      w_frame[2*c+1] = {w_sample[c][0], w_sample[c][1], w_sample[c][2],
                        w_sample[c][3], w_sample[c][4]};
    end
  end

  always_comb begin
    for (int l = 0; l < NLANE; l++) begin
      w_comb[l] = {4'd0, r_acc[l]} |
                  (w_load ? ({3'd0, w_frame[l]} << r_phase[1:0]) : 8'd0);
    end
    w_fclk_comb = {4'd0, r_fclk_acc} |
                  (w_load ? (8'b0000_0111 << r_phase[1:0]) : 8'd0);
  end

  always_ff @(posedge lclk_d4) begin
    if (rst) begin
      r_acc      <= '0;
      r_dout     <= '0;
      r_fclk_acc <= 4'd0;
      r_fclk     <= 4'd0;
      r_fs       <= 1'b0;
      r_en       <= 1'b0;
      r_mode     <= 2'd0;
      r_ramp     <= 10'd0;
      r_uf       <= 16'd0;
    end else begin
      for (int l = 0; l < NLANE; l++) begin
        r_acc[l]  <= w_comb[l][7:4];
        r_dout[l] <= w_comb[l][3:0];
      end
      r_fclk_acc <= w_fclk_comb[7:4];
      r_fclk     <= w_fclk_comb[3:0];
      r_fs       <= w_frame_start_nxt;
      if (r_phase == 3'd4) begin
        r_en   <= enable;
        r_mode <= mode;
      end
      if (w_load && r_en && (r_mode == 2'd1)) r_ramp <= r_ramp + 10'd1;
      if (w_din_ready && !din_valid && (r_uf != 16'hFFFF)) r_uf <= r_uf + 16'd1;
    end
  end

  assign din_ready     = w_din_ready;
  assign dout4b        = r_dout;
  assign fclk4b        = r_fclk;
  assign frame_start   = r_fs;
  assign underflow_cnt = r_uf;

endmodule
